ac_control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. It drives the control strobes of the existing datapath: PC, instruction register, accumulator/ALU and the unified memory port. It sits beside that datapath inside `cpu`. It consumes the latched instruction, the accumulator zero flag and a memory ready handshake, and includes a watchdog that halts the core on a stalled memory access.

---
 rtl/ac_control_unit.sv | 148 ++++++++++++++
 tb/tb_ac_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_control_unit.sv
// Fetch/decode/execute sequencer with a memory watchdog for the 8-bit accumulator CPU.
// Build option: define AC_COND_BRANCH_EN to enable JZ; otherwise opcode 110 decodes as NOP.
module ac_control_unit #(
  parameter int OPW     = 3,
  parameter int ADW     = 5,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic [OPW+ADW-1:0] ir_i,
  input  logic               acc_zero_i,
  input  logic               mem_ready_i,
  output logic               mem_rd_o,
  output logic               mem_we_o,
  output logic               addr_sel_o,
  output logic               ir_load_o,
  output logic               pc_inc_o,
  output logic               pc_load_o,
  output logic               acc_load_o,
  output logic [1:0]         alu_op_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_MEMWR  = 3'd3,
    S_JUMP   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_STA = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(6);
  localparam logic [OPW-1:0] OP_HLT = OPW'(7);
  localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

  state_t         state_q, state_d;
  logic [7:0]     wait_q, wait_d;
  logic [OPW-1:0] opcode;
  logic           mem_req;
  logic           jz_taken;
  logic           unused_addr_bits;

  assign opcode           = ir_i[OPW+ADW-1:ADW];
  assign mem_req          = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign unused_addr_bits = ^ir_i[ADW-1:0];

`ifdef AC_COND_BRANCH_EN
  assign jz_taken = acc_zero_i;
`else
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero_i;
  assign jz_taken        = 1'b0;
`endif

  // Counter is zero whenever a memory phase starts, since any non-waiting cycle clears it.
  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    if (mem_req && !mem_ready_i) begin
      if (wait_q == TIMEOUT_C) state_d = S_FAULT;
      else                     wait_d  = wait_q + 8'd1;
    end
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:                 state_d = S_FETCH;
          OP_LDA, OP_ADD, OP_SUB: state_d = S_MEMRD;
          OP_STA:                 state_d = S_MEMWR;
          OP_JMP:                 state_d = S_JUMP;
          OP_JZ:                  state_d = jz_taken ? S_JUMP : S_FETCH;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEMRD, S_MEMWR: if (mem_ready_i) state_d = S_FETCH;
      S_JUMP:           state_d = S_FETCH;
      S_HALT:           state_d = S_HALT;
      S_FAULT:          state_d = S_FAULT;
      default:          state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Moore decode; only the completion pulses look at same-cycle ready.
  always_comb begin
    mem_rd_o   = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    acc_load_o = 1'b0;
    alu_op_o   = 2'b00;
    halted_o   = 1'b0;
    fault_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_o  = 1'b1;
        ir_load_o = mem_ready_i;
        pc_inc_o  = mem_ready_i;
      end
      S_MEMRD: begin
        mem_rd_o   = 1'b1;
        addr_sel_o = 1'b1;
        acc_load_o = mem_ready_i;
        if (mem_ready_i) begin
          if (opcode == OP_ADD)      alu_op_o = 2'b01;
          else if (opcode == OP_SUB) alu_op_o = 2'b10;
          else                       alu_op_o = 2'b00;
        end
      end
      S_MEMWR: begin
        mem_we_o   = 1'b1;
        addr_sel_o = 1'b1;
      end
      S_JUMP:  pc_load_o = 1'b1;
      S_HALT:  halted_o  = 1'b1;
      S_FAULT: begin
        halted_o = 1'b1;
        fault_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_ac_control_unit.sv
// Bench for ac_control_unit: a behavioural datapath around the DUT, checked against an ISA-level timing model.
module tb_ac_control_unit;
  localparam int TIMEOUT = 15;
  localparam int LIM     = 160;
  localparam int EV_FETCH = 0, EV_ACC = 1, EV_PCL = 2, EV_WR = 3, EV_HALT = 4;
  localparam int RST_PAT   = int'(14'b1_0_0_0_0_0_0_00_0_0_000);
  localparam int FAULT_PAT = int'(14'b0_0_0_0_0_0_0_00_1_1_110);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, acc_zero, mem_ready;
  logic [7:0] ir;
  logic       mem_rd, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, halted, fault;
  logic [1:0] alu_op;
  logic [2:0] state;

  ac_control_unit #(.OPW(3), .ADW(5), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset(reset), .ir_i(ir), .acc_zero_i(acc_zero), .mem_ready_i(mem_ready),
    .mem_rd_o(mem_rd), .mem_we_o(mem_we), .addr_sel_o(addr_sel), .ir_load_o(ir_load),
    .pc_inc_o(pc_inc), .pc_load_o(pc_load), .acc_load_o(acc_load), .alu_op_o(alu_op),
    .halted_o(halted), .fault_o(fault), .state_o(state)
  );

  // Datapath driven by the DUT strobes
  logic [7:0] prog [32];
  logic [7:0] dmem [32];
  logic [4:0] pc;
  logic [7:0] acc;
  wire  [4:0] addr = addr_sel ? ir[4:0] : pc;
  assign acc_zero = (acc == 8'd0);

  always @(posedge clk) begin
    if (reset) begin
      dmem <= prog;
      pc   <= 5'd0;
      acc  <= 8'd0;
      ir   <= 8'd0;
    end else begin
      if (ir_load) ir <= dmem[addr];
      if (pc_inc) pc <= pc + 5'd1;
      else if (pc_load) pc <= ir[4:0];
      if (acc_load) begin
        case (alu_op)
          2'b00:   acc <= dmem[addr];
          2'b01:   acc <= acc + dmem[addr];
          2'b10:   acc <= acc - dmem[addr];
          default: acc <= acc;
        endcase
      end
      if (mem_we && mem_ready) dmem[addr] <= acc;
    end
  end

  typedef struct { int cyc; int kind; int val; } ev_t;
  ev_t exp_q[$];
  ev_t got_q[$];
  bit  rdy [LIM];
  bit  seen_halt;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int outs();
    return int'({mem_rd, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op, halted, fault, state});
  endfunction

  function automatic int pack(input ev_t e);
    return e.cyc * 4096 + e.kind * 256 + e.val;
  endfunction

  task automatic push_exp(input int t, input int kind, input int val);
    ev_t e;
    e.cyc = t; e.kind = kind; e.val = val;
    if (t < LIM) exp_q.push_back(e);
  endtask

  // Instruction-level model: walks the program and the ready sequence, predicting each event's cycle
  task automatic model_run(output logic [7:0] acc_out);
    logic [7:0] m [32];
    logic [7:0] macc, mir, v;
    int t, mpc, op, a;
    bit done;
    m = prog; t = 0; mpc = 0; macc = 8'd0; done = 1'b0;
    exp_q.delete();
    while (t < LIM && !done) begin
      while (t < LIM && !rdy[t]) t++;
      if (t >= LIM) break;
      push_exp(t, EV_FETCH, mpc);
      mir = m[mpc];
      mpc = (mpc + 1) % 32;
      t += 2;
      op = int'(mir[7:5]);
      a  = int'(mir[4:0]);
`ifndef AC_COND_BRANCH_EN
      if (op == 6) op = 0;
`endif
      if (op == 6) op = (macc == 8'd0) ? 5 : 0;
      case (op)
        1, 3, 4: begin
          while (t < LIM && !rdy[t]) t++;
          if (t >= LIM) break;
          v = m[a];
          push_exp(t, EV_ACC, (op == 1 ? 0 : op == 3 ? 1 : 2) * 32 + a);
          macc = (op == 1) ? v : (op == 3) ? macc + v : macc - v;
          t++;
        end
        2: begin
          while (t < LIM && !rdy[t]) t++;
          if (t >= LIM) break;
          push_exp(t, EV_WR, a);
          m[a] = macc;
          t++;
        end
        5: begin
          push_exp(t, EV_PCL, a);
          mpc = a;
          t++;
        end
        7: begin
          push_exp(t, EV_HALT, 0);
          done = 1'b1;
        end
        default: ;
      endcase
    end
    acc_out = macc;
  endtask

  task automatic observe(input int c);
    ev_t e;
    e.cyc = c;
    if (ir_load) begin e.kind = EV_FETCH; e.val = int'(addr); got_q.push_back(e); end
    if (acc_load) begin e.kind = EV_ACC; e.val = int'(alu_op) * 32 + int'(addr); got_q.push_back(e); end
    if (pc_load) begin e.kind = EV_PCL; e.val = int'(ir[4:0]); got_q.push_back(e); end
    if (mem_we && mem_ready) begin e.kind = EV_WR; e.val = int'(addr); got_q.push_back(e); end
    if (halted && !seen_halt) begin e.kind = EV_HALT; e.val = 0; got_q.push_back(e); seen_halt = 1'b1; end
    chk("invariants", int'({mem_rd & mem_we,
                            (int'(pc_inc) + int'(pc_load) + int'(acc_load)) > 1,
                            !acc_load && (alu_op != 2'b00)}), 0);
  endtask

  // Leaves the bench at the falling edge of cycle 0 (first cycle after reset)
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input string name);
    logic [7:0] macc;
    int n;
    model_run(macc);
    got_q.delete();
    seen_halt = 1'b0;
    do_reset();
    for (int c = 0; c < LIM; c++) begin
      mem_ready = rdy[c];
      #1;
      observe(c);
      @(negedge clk);
    end
    chk({name, "_nevents"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_event"}, pack(got_q[i]), pack(exp_q[i]));
    chk({name, "_acc"}, int'(acc), int'(macc));
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    for (int i = 0; i < LIM; i++) rdy[i] = 1'b1;
  endtask

  initial begin
    int run;
    reset = 1'b1;
    mem_ready = 1'b0;
    clear_prog();

    // Reset state, then the FETCH watchdog with ready held low
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      mem_ready = 1'b0;
      #1;
      if (c == 0)  chk("reset_outputs", outs(), RST_PAT);
      if (c == 15) chk("wd_still_fetch", int'(state), 0);
      if (c == 16) chk("wd_fault", outs(), FAULT_PAT);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("fault_sticky", outs(), FAULT_PAT);
    @(negedge clk);

    // Ready arriving on the exact timeout count completes the fetch
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      mem_ready = (c == 15);
      #1;
      if (c == 15) chk("wd_edge_ir_load", int'(ir_load), 1);
      if (c == 16) chk("wd_edge_decode", int'({fault, state}), 1);
      @(negedge clk);
    end

    // Reset in the middle of a stalled MEMRD
    clear_prog();
    prog[0] = 8'h30;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      mem_ready = (c == 0);
      if (c == 3) reset = 1'b1;
      if (c == 4) reset = 1'b0;
      #1;
      if (c == 3) chk("memrd_stalled", int'({mem_rd, addr_sel, state}), 8'b0001_1010);
      if (c == 4) chk("reset_mid_memrd", outs(), RST_PAT);
      @(negedge clk);
    end

    // LDA 0x10, ADD 0x11, HLT with zero-wait memory
    clear_prog();
    prog[0] = 8'h30; prog[1] = 8'h71; prog[2] = 8'hE0;
    prog[16] = 8'd5; prog[17] = 8'd7;
    run_prog("lda_add_hlt");
    chk("lda_add_hlt_sum", int'(acc), 12);

    // STA 0x1F with two wait cycles
    clear_prog();
    prog[0] = 8'h5F; prog[1] = 8'hE0;
    rdy[2] = 1'b0; rdy[3] = 1'b0;
    run_prog("sta_wait");

    // JZ with the flag set (ACC = 0 after reset)
    clear_prog();
    prog[0] = 8'hC5; prog[1] = 8'hE0; prog[5] = 8'hE0;
    run_prog("jz_zero");

    // JZ with the flag clear
    clear_prog();
    prog[0] = 8'h30; prog[1] = 8'hC5; prog[2] = 8'hE0; prog[5] = 8'hE0; prog[16] = 8'd3;
    run_prog("jz_nonzero");

    // Random programs and random memory wait states
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      run = 0;
      for (int c = 0; c < LIM; c++) begin
        rdy[c] = (run >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        run = rdy[c] ? 0 : run + 1;
      end
      run_prog($sformatf("random%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
